sram_prog_loader: RTL and testbench

- Reads a program image out of the board's asynchronous SRAM and streams it, one 16-bit word at a time, to the instruction scheduler over a valid/ready handshake.
- It is the read-side master of the SRAM port (DQ, ADDR, OE_N, WE_N, CE_N, LB_N, UB_N) that the GPU top currently ties off. The scheduler is the consumer.
- Image format: word at BASE_ADDR = length N; words BASE_ADDR+1 .. BASE_ADDR+N = payload.

---
 rtl/gpu_mem_pkg.sv | 17 +
 rtl/prog_word_fifo.sv | 52 +++++
 rtl/sram_prog_loader.sv | 140 ++++++++++++++
 tb/tb_sram_prog_loader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_mem_pkg.sv
// gpu_mem_pkg: shared SRAM geometry, program loader states and program size limit
// Ports: none (package)
package gpu_mem_pkg;
    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;
    // Sized to the scheduler's instruction memory; a longer image cannot be held
    localparam int PROG_MAX_WORDS = 1024;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_ADDR,
        ST_LEN_WAIT,
        ST_DAT_ADDR,
        ST_DAT_WAIT,
        ST_DRAIN,
        ST_DONE
    } ld_state_e;
endpackage

// File: rtl/prog_word_fifo.sv
// prog_word_fifo: synchronous FIFO with a registered head entry and same-cycle push/pop
// Ports: clk, rst_n (async active-low), push_i/din_i write side, pop_i read side,
//        head_o oldest entry, valid_o not empty, count_o occupancy
module prog_word_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] head_q;
    logic [PTR_W-1:0] rd_q, wr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, pop, body_empty, to_head, to_body;
    // The head register holds the oldest entry; the array holds everything behind it
    assign pop        = pop_i && cnt_q != '0;
    assign body_empty = cnt_q <= CNT_W'(1);
    assign to_head    = push_i && (cnt_q == '0 || (pop && body_empty));
    assign to_body    = push_i && !to_head;
    assign cnt_d      = cnt_q + CNT_W'(push_i) - CNT_W'(pop);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= cnt_d != '0;
            if (to_head) head_q <= din_i;
            else if (pop) head_q <= body_empty ? '0 : mem_q[rd_q];
            if (pop && !body_empty) rd_q <= rd_q + 1'b1;
            if (to_body) wr_q <= wr_q + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (to_body) mem_q[wr_q] <= din_i;
    end
    assign head_o  = head_q;
    assign valid_o = valid_q;
    assign count_o = cnt_q;
endmodule

// File: rtl/sram_prog_loader.sv
// sram_prog_loader: reads a length-prefixed program image from async SRAM and streams it out
// Ports: clk, reset (async active-low), start load request,
//        sram_* read-side SRAM master, word_* valid/ready output stream,
//        busy load in progress, done load finished and drained, len_err bad length word
module sram_prog_loader
    import gpu_mem_pkg::*;
#(
    parameter int                ADDR_W      = SRAM_ADDR_W,
    parameter int                DATA_W      = SRAM_DATA_W,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                MAX_WORDS   = PROG_MAX_WORDS,
    parameter int                WAIT_CYCLES = 1,
    parameter int                FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] sram_dq,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ce_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n,
    output logic [DATA_W-1:0] word_data,
    output logic              word_valid,
    output logic              word_last,
    input  logic              word_ready,
    output logic              busy,
    output logic              done,
    output logic              len_err
);
    localparam int REM_W = $clog2(MAX_WORDS + 1);
    localparam int WT_W  = $clog2(WAIT_CYCLES + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    ld_state_e         state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              oe_n_q, ce_n_q, busy_q, done_q, len_err_q;
    logic [WT_W-1:0]   wait_q;
    logic [REM_W-1:0]  rem_q;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [DATA_W:0]   head;
    logic              settled, push, len_bad;
    assign settled = wait_q == '0;
    // sram_dq is captured into the FIFO on the edge that ends the last wait cycle
    assign push    = state_q == ST_DAT_WAIT && settled;
    assign len_bad = sram_dq == '0 || 32'(sram_dq) > MAX_WORDS;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            oe_n_q    <= 1'b1;
            ce_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            len_err_q <= 1'b0;
            wait_q    <= '0;
            rem_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: if (start) begin
                    state_q   <= ST_LEN_ADDR;
                    addr_q    <= BASE_ADDR;
                    ce_n_q    <= 1'b0;
                    oe_n_q    <= 1'b0;
                    busy_q    <= 1'b1;
                    done_q    <= 1'b0;
                    len_err_q <= 1'b0;
                end
                ST_LEN_ADDR: begin
                    state_q <= ST_LEN_WAIT;
                    wait_q  <= WT_W'(WAIT_CYCLES - 1);
                end
                ST_LEN_WAIT: begin
                    if (!settled) wait_q <= wait_q - 1'b1;
                    else if (len_bad) begin
                        state_q   <= ST_DONE;
                        len_err_q <= 1'b1;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        ce_n_q    <= 1'b1;
                        oe_n_q    <= 1'b1;
                    end else begin
                        state_q <= ST_DAT_ADDR;
                        rem_q   <= REM_W'(sram_dq);
                        addr_q  <= BASE_ADDR + 1'b1;
                    end
                end
                // Stall here with the address driven until a FIFO slot is free; with a
                // single read in flight that slot is still free when the word lands
                ST_DAT_ADDR: if (fifo_cnt < CNT_W'(FIFO_DEPTH)) begin
                    state_q <= ST_DAT_WAIT;
                    wait_q  <= WT_W'(WAIT_CYCLES - 1);
                end
                ST_DAT_WAIT: begin
                    if (!settled) wait_q <= wait_q - 1'b1;
                    else begin
                        rem_q  <= rem_q - 1'b1;
                        addr_q <= addr_q + 1'b1;
                        if (rem_q == REM_W'(1)) begin
                            state_q <= ST_DRAIN;
                            ce_n_q  <= 1'b1;
                            oe_n_q  <= 1'b1;
                        end else state_q <= ST_DAT_ADDR;
                    end
                end
                ST_DRAIN: if (fifo_cnt == '0) begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
    prog_word_fifo #(
        .WIDTH(DATA_W + 1),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (reset),
        .push_i (push),
        .din_i  ({rem_q == REM_W'(1), sram_dq}),
        .pop_i  (word_ready),
        .head_o (head),
        .valid_o(word_valid),
        .count_o(fifo_cnt)
    );
    assign word_data = head[DATA_W-1:0];
    assign word_last = head[DATA_W];
    assign sram_addr = addr_q;
    assign sram_oe_n = oe_n_q;
    assign sram_ce_n = ce_n_q;
    assign sram_we_n = 1'b1;
    assign sram_lb_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign busy      = busy_q;
    assign done      = done_q;
    assign len_err   = len_err_q;
endmodule

// File: tb/tb_sram_prog_loader.sv
// tb_sram_prog_loader: directed bench for the SRAM program loader
module tb_sram_prog_loader;
    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, start_w = 1'b0;
    logic        word_ready = 1'b0, ready_w = 1'b1;
    logic [15:0] sram_dq, dq_w, word_data, data_w;
    logic [19:0] sram_addr, addr_w;
    logic        sram_oe_n, sram_we_n, sram_ce_n, sram_lb_n, sram_ub_n;
    logic        oe_w, we_w, ce_w, lb_w, ub_w;
    logic        word_valid, word_last, busy, done, len_err;
    logic        valid_w, last_w, busy_w, done_w, len_err_w;
    logic [15:0] mem0 [16];
    logic [15:0] memw [16];
    logic [31:0] rx[$], rxw[$], alog[$], alogw[$];
    int          checks = 0, failures = 0, cyc = 0, s_cyc = 0, first_cyc = -1;
    bit          saw_valid = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    assign sram_dq = (!sram_ce_n && !sram_oe_n) ? mem0[sram_addr[3:0]] : 16'hDEAD;
    assign dq_w    = (!ce_w && !oe_w) ? memw[addr_w[3:0]] : 16'hDEAD;

    sram_prog_loader dut (
        .clk(clk), .reset(reset), .start(start), .sram_dq(sram_dq),
        .sram_addr(sram_addr), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_ce_n(sram_ce_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n),
        .word_data(word_data), .word_valid(word_valid), .word_last(word_last),
        .word_ready(word_ready), .busy(busy), .done(done), .len_err(len_err)
    );

    sram_prog_loader #(.BASE_ADDR(20'hFFFFE)) dut_w (
        .clk(clk), .reset(reset), .start(start_w), .sram_dq(dq_w),
        .sram_addr(addr_w), .sram_oe_n(oe_w), .sram_we_n(we_w),
        .sram_ce_n(ce_w), .sram_lb_n(lb_w), .sram_ub_n(ub_w),
        .word_data(data_w), .word_valid(valid_w), .word_last(last_w),
        .word_ready(ready_w), .busy(busy_w), .done(done_w), .len_err(len_err_w)
    );

    // Inputs change #1 after posedge, so negedge values are what the next edge samples
    always @(negedge clk) begin
        if (word_valid && word_ready) rx.push_back({15'b0, word_last, word_data});
        if (word_valid) saw_valid = 1'b1;
        if (word_valid && first_cyc < 0) first_cyc = cyc;
        if (!sram_ce_n && !sram_oe_n && (alog.size() == 0 || alog[$] != {12'b0, sram_addr}))
            alog.push_back({12'b0, sram_addr});
        if (valid_w && ready_w) rxw.push_back({15'b0, last_w, data_w});
        if (!ce_w && !oe_w && (alogw.size() == 0 || alogw[$] != {12'b0, addr_w}))
            alogw.push_back({12'b0, addr_w});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rx.delete();
        alog.delete();
        saw_valid = 1'b0;
        first_cyc = -1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        s_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'b0, done}, 32'd1);
    endtask

    task automatic chk_words(input string tag, input int n);
        chk({tag, "_cnt"}, rx.size(), n);
        for (int i = 0; i < n && i < rx.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), rx[i], ((i == n - 1) ? 32'h1_0000 : 32'h0) + 32'hA001 + i);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem0[i] = 16'hA000 + 16'(i);
        for (int i = 0; i < 16; i++) memw[i] = 16'h0BAD;
        // Reset values
        @(negedge clk);
        chk("rst_addr", {12'b0, sram_addr}, 32'h0);
        chk("rst_oe_ce", {30'b0, sram_oe_n, sram_ce_n}, 32'h3);
        chk("rst_stream", {14'b0, word_valid, word_last, word_data}, 32'h0);
        chk("rst_flags", {29'b0, busy, done, len_err}, 32'h0);
        chk("rst_consts", {29'b0, sram_we_n, sram_lb_n, sram_ub_n}, 32'h4);
        @(posedge clk); #1;
        reset = 1'b1;

        // 1: basic three-word load with ready high
        mem0[0] = 16'd3;
        word_ready = 1'b1;
        clear_logs();
        pulse_start();
        wait_done("t1_done");
        chk_words("t1", 3);
        chk("t1_first_valid", first_cyc - s_cyc, 32'd5);
        chk("t1_addr_cnt", alog.size(), 32'd4);
        for (int i = 0; i < 4 && i < alog.size(); i++) chk($sformatf("t1_addr%0d", i), alog[i], i);
        chk("t1_idle_out", {29'b0, word_valid, word_last, busy}, 32'h0);
        chk("t1_len_err", {31'b0, len_err}, 32'h0);

        // 2a: consumer stalled, all words buffered and held
        word_ready = 1'b0;
        clear_logs();
        pulse_start();
        repeat (20) @(negedge clk);
        chk("t2a_hold", {15'b0, word_valid, word_data}, 32'h1A001);
        chk("t2a_drain", {30'b0, busy, sram_ce_n}, 32'h3);
        @(posedge clk); #1;
        word_ready = 1'b1;
        wait_done("t2a_done");
        chk_words("t2a", 3);

        // 2b: N=8 fills the FIFO and stalls on address 5, then ready toggles
        mem0[0] = 16'd8;
        word_ready = 1'b0;
        clear_logs();
        pulse_start();
        repeat (20) @(negedge clk);
        chk("t2b_stall_addr", {12'b0, sram_addr}, 32'h5);
        chk("t2b_stall_en", {29'b0, sram_ce_n, sram_oe_n, busy}, 32'h1);
        chk("t2b_hold", {15'b0, word_valid, word_data}, 32'h1A001);
        for (int n = 0; n < 400 && !done; n++) begin
            @(posedge clk); #1;
            word_ready = ~word_ready;
        end
        @(negedge clk);
        chk("t2b_done", {31'b0, done}, 32'd1);
        chk_words("t2b", 8);
        word_ready = 1'b1;

        // 3: zero length
        mem0[0] = 16'd0;
        clear_logs();
        pulse_start();
        wait_done("t3_done");
        chk("t3_len_err", {31'b0, len_err}, 32'd1);
        chk("t3_ce_oe", {30'b0, sram_ce_n, sram_oe_n}, 32'h3);
        chk("t3_no_valid", {31'b0, saw_valid}, 32'd0);
        mem0[0] = 16'd2;
        clear_logs();
        pulse_start();
        chk("t3_restart_flags", {29'b0, busy, done, len_err}, 32'h4);
        wait_done("t3_restart_done");
        chk("t3_restart_len_err", {31'b0, len_err}, 32'd0);
        chk_words("t3r", 2);

        // 4: length one past the limit, no payload reads
        mem0[0] = 16'd1025;
        clear_logs();
        pulse_start();
        wait_done("t4_done");
        chk("t4_len_err", {31'b0, len_err}, 32'd1);
        chk("t4_addr_cnt", alog.size(), 32'd1);
        chk("t4_no_valid", {31'b0, saw_valid}, 32'd0);

        // 5: reset during the second payload read
        mem0[0] = 16'd8;
        word_ready = 1'b0;
        clear_logs();
        pulse_start();
        begin
            int n = 0;
            while (!(sram_addr == 20'h2 && !sram_oe_n) && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("t5_reach_read2", {31'b0, sram_addr == 20'h2}, 32'd1);
        end
        chk("t5_pre_valid", {31'b0, word_valid}, 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("t5_rst_addr", {12'b0, sram_addr}, 32'h0);
        chk("t5_rst_oe_ce", {30'b0, sram_oe_n, sram_ce_n}, 32'h3);
        chk("t5_rst_stream", {14'b0, word_valid, word_last, word_data}, 32'h0);
        chk("t5_rst_flags", {29'b0, busy, done, len_err}, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        word_ready = 1'b1;
        clear_logs();
        pulse_start();
        wait_done("t5_done");
        chk_words("t5", 8);

        // 6: address wrap from the top of SRAM, with an ignored start mid-load
        memw[14] = 16'd2;
        memw[15] = 16'hB00F;
        memw[0]  = 16'hB000;
        rxw.delete();
        alogw.delete();
        @(posedge clk); #1 start_w = 1'b1;
        @(posedge clk); #1 start_w = 1'b0;
        repeat (2) @(posedge clk);
        #1 start_w = 1'b1;
        @(posedge clk); #1 start_w = 1'b0;
        for (int n = 0; n < 200 && !done_w; n++) @(negedge clk);
        chk("t6_done", {31'b0, done_w}, 32'd1);
        chk("t6_cnt", rxw.size(), 32'd2);
        if (rxw.size() == 2) begin
            chk("t6_w0", rxw[0], 32'h0B00F);
            chk("t6_w1", rxw[1], 32'h1B000);
        end
        chk("t6_addr_cnt", alogw.size(), 32'd3);
        if (alogw.size() == 3) begin
            chk("t6_addr0", alogw[0], 32'hFFFFE);
            chk("t6_addr1", alogw[1], 32'hFFFFF);
            chk("t6_addr2", alogw[2], 32'h00000);
        end
        chk("t6_len_err", {31'b0, len_err_w}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
